// File: rtl/dec_hamming_if.sv
// Valid/ready stream bundle for the Hamming(7,4) decoder: codeword in, corrected word out.
// master = producer/consumer side, slave = the decoder itself.
interface dec_hamming_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_err;
  logic [2:0] out_syndrome;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_syndrome
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_err, out_syndrome
  );
endinterface

// File: rtl/dec_hamming.sv
// Two-stage pipelined Hamming(7,4) single-error corrector with valid/ready on both sides
// and a saturating count of corrected words delivered downstream.
module dec_hamming #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  dec_hamming_if.slave     bus,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s2_adv;
  logic             s1_adv;
  logic [2:0]       syn_in;
  logic [7:0]       flip_onehot;
  logic [6:0]       corr_code;

  logic             s1_valid_q, s1_valid_d;
  logic [6:0]       s1_code_q,  s1_code_d;
  logic [2:0]       s1_syn_q,   s1_syn_d;
  logic             s2_valid_q, s2_valid_d;
  logic [3:0]       s2_data_q,  s2_data_d;
  logic             s2_err_q,   s2_err_d;
  logic [2:0]       s2_syn_q,   s2_syn_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  assign s2_adv      = ~s2_valid_q | bus.out_ready;
  assign s1_adv      = ~s1_valid_q | s2_adv;
  assign bus.in_ready = s1_adv;

  assign syn_in[0] = bus.in_code[0] ^ bus.in_code[2] ^ bus.in_code[4] ^ bus.in_code[6];
  assign syn_in[1] = bus.in_code[1] ^ bus.in_code[2] ^ bus.in_code[5] ^ bus.in_code[6];
  assign syn_in[2] = bus.in_code[3] ^ bus.in_code[4] ^ bus.in_code[5] ^ bus.in_code[6];

  // A zero syndrome shifts the one-hot into bit 0, which is dropped, so nothing flips.
  assign flip_onehot = 8'd1 << s1_syn_q;
  assign corr_code   = s1_code_q ^ flip_onehot[7:1];

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_code_d   = s1_code_q;
    s1_syn_d    = s1_syn_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_err_d    = s2_err_q;
    s2_syn_d    = s2_syn_q;
    err_count_d = err_count_q;

    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_code_d = bus.in_code;
        s1_syn_d  = syn_in;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = {corr_code[6], corr_code[5], corr_code[4], corr_code[2]};
        s2_err_d  = (s1_syn_q != 3'd0);
        s2_syn_d  = s1_syn_q;
      end
    end

    if (clr_count) begin
      err_count_d = '0;
    end else if (s2_valid_q && bus.out_ready && s2_err_q && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_syn_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_err_q    <= 1'b0;
      s2_syn_q    <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s1_syn_q    <= s1_syn_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_err_q    <= s2_err_d;
      s2_syn_q    <= s2_syn_d;
      err_count_q <= err_count_d;
    end
  end

  // Output fields read as zero whenever no word is presented.
  assign bus.out_valid    = s2_valid_q;
  assign bus.out_data     = s2_valid_q ? s2_data_q : 4'd0;
  assign bus.out_err      = s2_valid_q ? s2_err_q  : 1'b0;
  assign bus.out_syndrome = s2_valid_q ? s2_syn_q  : 3'd0;
  assign err_count        = err_count_q;

endmodule

// File: tb/tb_dec_hamming.sv
// Bench for dec_hamming: vector table, directed corner sequences and random traffic
// checked against a nearest-codeword reference model and an expected-output queue.
module tb_dec_hamming;

  typedef struct {
    logic [3:0] d;
    logic       e;
    logic [2:0] s;
  } exp_t;

  typedef struct {
    logic [6:0] code;
    logic [3:0] d;
    logic       e;
    logic [2:0] s;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_count;
  logic [7:0] err_count;
  logic       clr2;
  logic [1:0] cnt2;

  dec_hamming_if hif ();
  dec_hamming_if hif2 ();

  dec_hamming #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(hif.slave), .clr_count(clr_count), .err_count(err_count)
  );

  dec_hamming #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(hif2.slave), .clr_count(clr2), .err_count(cnt2)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int   cnt_m = 0;
  int   n_acc = 0;
  int   n_out = 0;

  logic       smp_valid;
  logic       smp_in_ready;
  logic [3:0] smp_data;
  logic       smp_err;
  logic [2:0] smp_syn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  // Hamming(7,4) is perfect: every 7-bit word lies within distance 1 of exactly one codeword.
  function automatic exp_t ref_decode(input logic [6:0] c);
    exp_t       r;
    logic [6:0] diff;
    r.d = 4'd0; r.e = 1'b0; r.s = 3'd0;
    for (int dd = 0; dd < 16; dd++) begin
      diff = c ^ encode(4'(dd));
      if ($countones(diff) <= 1) begin
        r.d = 4'(dd);
        r.e = (diff != 7'd0);
        for (int k = 0; k < 7; k++)
          if (diff[k]) r.s = 3'(k + 1);
      end
    end
    return r;
  endfunction

  task automatic cyc(input bit v, input logic [6:0] code, input bit ordy, input bit clr);
    exp_t e;
    bit   xfer_err;
    @(negedge clk);
    hif.in_valid  = v;
    hif.in_code   = code;
    hif.out_ready = ordy;
    clr_count     = clr;
    #1;
    smp_valid    = hif.out_valid;
    smp_in_ready = hif.in_ready;
    smp_data     = hif.out_data;
    smp_err      = hif.out_err;
    smp_syn      = hif.out_syndrome;
    xfer_err     = 1'b0;
    chk("err_count", 32'(err_count), 32'(cnt_m));
    if (hif.out_valid) begin
      if (ordy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(hif.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(hif.out_data), 32'(e.d));
          chk("out_err", 32'(hif.out_err), 32'(e.e));
          chk("out_syndrome", 32'(hif.out_syndrome), 32'(e.s));
          xfer_err = e.e;
          n_out++;
        end
      end
    end else begin
      chk("idle_mask", 32'({hif.out_data, hif.out_err, hif.out_syndrome}), 32'd0);
    end
    if (v && hif.in_ready) begin
      exp_q.push_back(ref_decode(code));
      n_acc++;
    end
    if (clr) cnt_m = 0;
    else if (xfer_err && cnt_m < 255) cnt_m++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    hif.in_valid  = 1'b0;
    hif.out_ready = 1'b1;
    clr_count     = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(hif.out_valid), 32'd0);
    chk("rst_in_ready", 32'(hif.in_ready), 32'd1);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_out_fields", 32'({hif.out_data, hif.out_err, hif.out_syndrome}), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    cnt_m = 0;
  endtask

  vec_t vecs[10];

  initial begin
    int   acc0, out0, vcount, nrdy, nerr;
    logic [3:0] h_data;
    logic       h_err;
    logic [2:0] h_syn;

    rst = 1'b1; clr_count = 1'b0; clr2 = 1'b0;
    hif.in_valid = 1'b0; hif.in_code = 7'd0; hif.out_ready = 1'b1;
    hif2.in_valid = 1'b0; hif2.in_code = 7'd0; hif2.out_ready = 1'b1;

    vecs[0] = '{7'h55, 4'hB, 1'b0, 3'd0};
    vecs[1] = '{7'h45, 4'hB, 1'b1, 3'd5};
    vecs[2] = '{7'h54, 4'hB, 1'b1, 3'd1};
    vecs[3] = '{7'h00, 4'h0, 1'b0, 3'd0};
    vecs[4] = '{7'h7F, 4'hF, 1'b0, 3'd0};
    vecs[5] = '{7'h7E, 4'hF, 1'b1, 3'd1};
    vecs[6] = '{7'h3F, 4'hF, 1'b1, 3'd7};
    vecs[7] = '{7'h04, 4'h0, 1'b1, 3'd3};
    vecs[8] = '{7'h08, 4'h0, 1'b1, 3'd4};
    vecs[9] = '{7'h03, 4'h1, 1'b1, 3'd3};   // double error, miscorrected

    do_reset();

    nerr = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, vecs[i].code, 1'b1, 1'b0);
      chk("tbl_in_ready", 32'(smp_in_ready), 32'd1);
      cyc(1'b0, 7'd0, 1'b1, 1'b0);
      chk("tbl_latency_early", 32'(smp_valid), 32'd0);
      cyc(1'b0, 7'd0, 1'b1, 1'b0);
      chk("tbl_valid", 32'(smp_valid), 32'd1);
      chk("tbl_data", 32'(smp_data), 32'(vecs[i].d));
      chk("tbl_err", 32'(smp_err), 32'(vecs[i].e));
      chk("tbl_syn", 32'(smp_syn), 32'(vecs[i].s));
      if (vecs[i].e) nerr++;
    end
    cyc(1'b0, 7'd0, 1'b1, 1'b0);
    chk("tbl_err_count", 32'(err_count), 32'(nerr));

    // Full-rate stream of every data value with every single-bit flip.
    do_reset();
    vcount = 0; nrdy = 0;
    for (int d = 0; d < 16; d++)
      for (int b = 0; b < 7; b++) begin
        cyc(1'b1, encode(4'(d)) ^ 7'(1 << b), 1'b1, 1'b0);
        if (smp_valid) vcount++;
        if (!smp_in_ready) nrdy++;
      end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 7'd0, 1'b1, 1'b0);
      if (smp_valid) vcount++;
    end
    chk("stream_outputs", 32'(vcount), 32'd112);
    chk("stream_stalls", 32'(nrdy), 32'd0);
    chk("stream_err_count", 32'(err_count), 32'd112);

    // Backpressure: consumer stalls while producer keeps offering words.
    do_reset();
    acc0 = n_acc; out0 = n_out;
    h_data = 4'd0; h_err = 1'b0; h_syn = 3'd0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, encode(4'(i + 3)) ^ 7'(1 << i), 1'b0, 1'b0);
      if (i == 2) begin
        h_data = smp_data; h_err = smp_err; h_syn = smp_syn;
        chk("bp_valid", 32'(smp_valid), 32'd1);
      end else if (i > 2) begin
        chk("bp_hold", 32'({smp_valid, smp_data, smp_err, smp_syn}),
            32'({1'b1, h_data, h_err, h_syn}));
      end
    end
    chk("bp_accepts", 32'(n_acc - acc0), 32'd2);
    chk("bp_in_ready", 32'(smp_in_ready), 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 7'd0, 1'b1, 1'b0);
    chk("bp_delivered", 32'(n_out - out0), 32'd2);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Simultaneous in/out transfer with both stages full, then mid-stream reset.
    cyc(1'b1, 7'h45, 1'b0, 1'b0);
    cyc(1'b1, 7'h54, 1'b0, 1'b0);
    cyc(1'b1, 7'h3F, 1'b1, 1'b0);
    chk("shift_in_ready", 32'(smp_in_ready), 32'd1);
    cyc(1'b1, 7'h7E, 1'b0, 1'b0);
    cyc(1'b1, 7'h04, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 7'd0, 1'b1, 1'b0);
    chk("rst_discard_count", 32'(err_count), 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 7'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 49) == 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 7'd0, 1'b1, 1'b0);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // Narrow counter: saturation, then clear winning over a same-cycle increment.
    @(negedge clk);
    hif2.in_valid = 1'b1; hif2.in_code = 7'h45; hif2.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    hif2.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("sat_count", 32'(cnt2), 32'd3);
    hif2.in_valid = 1'b1; hif2.in_code = 7'h54;
    @(negedge clk);
    hif2.in_valid = 1'b0;
    @(negedge clk);
    clr2 = 1'b1;
    #1;
    chk("clr_xfer_valid", 32'(hif2.out_valid & hif2.out_err), 32'd1);
    @(negedge clk);
    clr2 = 1'b0;
    #1;
    chk("clr_wins", 32'(cnt2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dec_hamming.md
Name: dec_hamming

Overview:
Pipelined Hamming(7,4) decoder/corrector. It consumes the 7-bit codewords produced by the project's 4-bit Hamming encoder stage and corrects any single-bit error. It returns the 4-bit data word with an error flag, the syndrome, and a saturating count of corrected words. The block sits directly downstream of the encoder, between the channel/injection logic and the display/consumer logic. Upstream and downstream use valid/ready handshakes.

Parameters:
CNT_W, 8, width of the corrected-error counter err_count (valid range 1..16).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_code holds a codeword
in_ready  output  1  block accepts in_code this cycle
in_code  input  7  codeword {d3,d2,d1,p3,d0,p2,p1}; bit0 = Hamming position 1
out_valid  output  1  out_* fields valid
out_ready  input  1  consumer accepts output
out_data  output  4  corrected data {d3,d2,d1,d0}
out_err  output  1  syndrome was nonzero and one bit was corrected
out_syndrome  output  3  {s3,s2,s1}; nonzero value = 1-based erroneous bit position
err_count  output  CNT_W  number of delivered words with out_err=1, saturating
clr_count  input  1  synchronous clear of err_count

Behaviour:
- Codeword map: p1=c[0], p2=c[1], d0=c[2], p3=c[3], d1=c[4], d2=c[5], d3=c[6].
- Syndrome bits:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s3 = c3^c4^c5^c6
- Correction: if the syndrome S != 0, invert c[S-1]. Then extract the data bits.
- Double errors are not detected. They are miscorrected as single errors; this is by design (no SECDED).
- Pipeline stages:
  - Stage 1 registers in_code and the syndrome (s1_valid).
  - Stage 2 registers out_data, out_err and out_syndrome (s2_valid = out_valid).
- Input handshake: an input transfer occurs when in_valid & in_ready.
- Output handshake: an output transfer occurs when out_valid & out_ready.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+2 when out_ready stays 1.
- Throughput: full, one word per cycle with no bubbles.
- Stage advance rules:
  - s2_adv = ~s2_valid | out_ready
  - s1_adv = ~s1_valid | s2_adv
  - in_ready = s1_adv, combinational; it depends only on registered state and out_ready, never on in_valid.
- Backpressure: while out_valid=1 and out_ready=0, the out_* fields hold stable and no word is dropped or duplicated. Both stages fill, then in_ready drops to 0.
- A stage that does not advance holds its contents.
- A stage whose upstream has no valid word becomes empty. Data registers may keep stale values while the stage is invalid.
- Invalid-output masking: out_data, out_err and out_syndrome are forced to 0 whenever out_valid=0.
- err_count update:
  - Increments by 1 on each output transfer with out_err=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_count=1 sets it to 0 on the next edge, even if an increment occurs the same cycle (clear wins).
- Reset values when rst=1 at an edge: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_err=0, out_syndrome=0, err_count=0.
- Reset applied mid-stream: all in-flight words are discarded, not delivered, and not counted.
- Output during reset: in_ready=1 during and after reset, because both stages are empty.
- Simultaneous input and output transfer with both stages full: everything shifts by one stage in the same edge.

Test Plan:
- Reset then in_code=7'h55 (data 4'b1011), out_ready=1 -> two edges later: out_valid=1, out_data=4'hB, out_err=0, out_syndrome=3'b000, err_count=0.
- in_code=7'h45 (bit4/d1 flipped) -> out_data=4'hB, out_err=1, out_syndrome=3'b101, err_count=1 after the transfer. Then in_code=7'h54 (p1 flipped) -> out_data=4'hB, out_syndrome=3'b001, err_count=2.
- Stream all 16 data values encoded (e.g. 4'h0->7'h00, 4'hF->7'h7F) each with every single-bit flip (112 words) back-to-back, out_ready=1 -> one output per cycle, all data correct, err_count=112.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 streams -> in_ready=0 after two accepts, out_* stable. Release -> words emerge in order, none lost or duplicated.
- CNT_W=2: deliver 5 erroneous words -> err_count saturates at 3. clr_count=1 in the same cycle as an erroneous output transfer -> err_count=0.
- Assert rst with both stages full -> next cycle out_valid=0, in_ready=1, err_count=0. The discarded words never appear on the output.
